// File: rtl/inst_encoder.sv
// RV32I field-to-instruction encoder with immediate range checks,
// a 2-entry output buffer and saturating statistics counters.
package riscv_pkg;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

module inst_encoder
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic signed [31:0] simm;
  logic is_r, is_i, is_s, is_b, is_j, is_u;
  logic fit_12, fit_b, fit_j;
  logic [31:0] enc_instr;
  logic enc_err;

  assign simm = in_imm;

  assign is_r = in_opcode == OP_R_TYPE;
  assign is_i = (in_opcode == OP_I_TYPE)
             || (in_opcode == OP_LOAD)
             || (in_opcode == OP_JALR);
  assign is_s = in_opcode == OP_STORE;
  assign is_b = in_opcode == OP_BRANCH;
  assign is_j = in_opcode == OP_JAL;
  assign is_u = (in_opcode == OP_LUI)
             || (in_opcode == OP_AUIPC);

  assign fit_12 = (simm >= -32'sd2048)
               && (simm <= 32'sd2047);
  assign fit_b = (simm >= -32'sd4096)
              && (simm <= 32'sd4094)
              && !in_imm[0];
  assign fit_j = (simm >= -32'sd1048576)
              && (simm <= 32'sd1048574)
              && !in_imm[0];

  always_comb begin
    enc_instr = INSTR_NOP;
    enc_err   = 1'b1;
    unique case (1'b1)
      is_r: begin
        enc_instr = {in_funct7, in_rs2, in_rs1,
                     in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      is_i: begin
        enc_instr = {in_imm[11:0], in_rs1,
                     in_funct3, in_rd, in_opcode};
        enc_err   = !fit_12;
      end
      is_s: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1,
                     in_funct3, in_imm[4:0], in_opcode};
        enc_err   = !fit_12;
      end
      is_b: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2,
                     in_rs1, in_funct3, in_imm[4:1],
                     in_imm[11], in_opcode};
        enc_err   = !fit_b;
      end
      is_j: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11],
                     in_imm[19:12], in_rd, in_opcode};
        enc_err   = !fit_j;
      end
      is_u: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = in_imm[11:0] != 12'h000;
      end
      default: ;
    endcase
    if (enc_err) enc_instr = INSTR_NOP;
  end

  logic [1:0]  count;
  logic [31:0] tail_instr;
  logic        tail_err;
  logic        push, pop;

  assign in_ready  = !count[1];
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is a dedicated register so it keeps its value once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      out_instr  <= 32'h0;
      out_err    <= 1'b0;
      tail_instr <= 32'h0;
      tail_err   <= 1'b0;
    end else begin
      if (pop && count == 2'd2) begin
        out_instr <= tail_instr;
        out_err   <= tail_err;
      end else if (push && (count == 2'd0 || pop)) begin
        out_instr <= enc_instr;
        out_err   <= enc_err;
      end else if (push) begin
        tail_instr <= enc_instr;
        tail_err   <= enc_err;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (push) begin
      if (enc_count != '1)
        enc_count <= enc_count + 1'b1;
      if (enc_err && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

endmodule
